// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and state encodings for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_DIVU = 4'b0110;
    localparam logic [3:0] OP_REMU = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_ROL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_NON  = 4'b1111;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MD_MUL = 2'd0,
        MD_DIV = 2'd1,
        MD_REM = 2'd2
    } md_op_t;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiplier / restoring divider: one step per cycle, WIDTH steps.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start_i,
    input  md_op_t           op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             ovf_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic                 busy_q;
    md_op_t               op_q;
    logic [CW-1:0]        count_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opnd_q;

    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic                 div_ge;

    // acc_q is {high product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_trial = div_shift - {1'b0, opnd_q};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        if (op_q == MD_MUL) begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
            acc_step = {(div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ge};
        end
    end

    assign done_o   = busy_q && (count_q == LAST);
    assign result_o = (op_q == MD_REM) ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
    assign carry_o  = (op_q == MD_MUL) && (|acc_step[2*WIDTH-1:WIDTH]);
    assign ovf_o    = (op_q != MD_MUL) && (opnd_q == '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_q  <= 1'b0;
            op_q    <= MD_MUL;
            count_q <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
        end else if (start_i) begin
            busy_q  <= 1'b1;
            op_q    <= op_i;
            count_q <= '0;
            if (op_i == MD_MUL) begin
                acc_q  <= {{WIDTH{1'b0}}, b_i};
                opnd_q <= a_i;
            end else begin
                acc_q  <= {{WIDTH{1'b0}}, a_i};
                opnd_q <= b_i;
            end
        end else if (busy_q) begin
            acc_q   <= acc_step;
            count_q <= count_q + CW'(1);
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready on both sides; single-cycle ops finish in one
// cycle, MUL/DIVU/REMU are handed to the iterative unit.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [3:0]       S_ALU,
    input  logic [WIDTH-1:0] DATA_A,
    input  logic [WIDTH-1:0] DATA_B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic [3:0]       FLAG_OUT
);

    localparam int SHW = $clog2(WIDTH);

    // Handshake: a request transfers on a rising CLK edge where IN_VALID & IN_READY;
    // a result transfers on an edge where OUT_VALID & OUT_READY, and is held until then.

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   alu_out_q, alu_out_d;
    logic [3:0]         flag_q, flag_d;

    logic               accept;
    logic               md_start;
    md_op_t             md_op;
    logic               md_done;
    logic [WIDTH-1:0]   md_result;
    logic               md_carry;
    logic               md_ovf;

    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     add_x, sub_x, sll_x, srl_x, sra_x;
    logic [2*WIDTH-1:0] rol_x;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_c, sc_v, sc_keep;

    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_S] = r[WIDTH-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    // Shifts carry one extra bit so the last bit shifted out falls out as C.
    always_comb begin
        sh    = DATA_B[SHW-1:0];
        add_x = {1'b0, DATA_A} + {1'b0, DATA_B};
        sub_x = {1'b0, DATA_A} - {1'b0, DATA_B};
        sll_x = {1'b0, DATA_A} << sh;
        srl_x = {DATA_A, 1'b0} >> sh;
        sra_x = $unsigned($signed({DATA_A, 1'b0}) >>> sh);
        rol_x = {DATA_A, DATA_A} << sh;

        sc_res  = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        sc_keep = 1'b0;
        case (S_ALU)
            OP_ADD: begin
                sc_res = add_x[WIDTH-1:0];
                sc_c   = add_x[WIDTH];
                sc_v   = (DATA_A[WIDTH-1] == DATA_B[WIDTH-1]) &&
                         (add_x[WIDTH-1] != DATA_A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_x[WIDTH-1:0];
                sc_c   = sub_x[WIDTH];
                sc_v   = (DATA_A[WIDTH-1] != DATA_B[WIDTH-1]) &&
                         (sub_x[WIDTH-1] != DATA_A[WIDTH-1]);
            end
            OP_AND: sc_res = DATA_A & DATA_B;
            OP_OR:  sc_res = DATA_A | DATA_B;
            OP_XOR: sc_res = DATA_A ^ DATA_B;
            OP_SLL: begin
                sc_res = sll_x[WIDTH-1:0];
                sc_c   = sll_x[WIDTH];
            end
            OP_ROL: begin
                sc_res = rol_x[2*WIDTH-1:WIDTH];
                sc_c   = (sh != '0) && rol_x[WIDTH];
            end
            OP_SRL: begin
                sc_res = srl_x[WIDTH:1];
                sc_c   = srl_x[0];
            end
            OP_SRA: begin
                sc_res = sra_x[WIDTH:1];
                sc_c   = sra_x[0];
            end
            OP_NON:  sc_keep = 1'b1;
            default: sc_keep = 1'b1;
        endcase
    end

    always_comb begin
        md_op = MD_REM;
        if (S_ALU == OP_MUL) begin
            md_op = MD_MUL;
        end else if (S_ALU == OP_DIVU) begin
            md_op = MD_DIV;
        end
    end

    assign IN_READY  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && OUT_READY);
    assign accept    = IN_VALID && IN_READY;
    assign OUT_VALID = (state_q == ST_DONE);
    assign ALU_OUT   = alu_out_q;
    assign FLAG_OUT  = flag_q;

    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_out_q;
        flag_d    = flag_q;
        md_start  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if ((state_q == ST_DONE) && OUT_READY) begin
                    state_d = ST_IDLE;
                end
                if (accept) begin
                    if (is_iterative(S_ALU)) begin
                        state_d  = ST_BUSY;
                        md_start = 1'b1;
                    end else begin
                        state_d   = ST_DONE;
                        alu_out_d = sc_res;
                        if (!sc_keep) begin
                            flag_d = pack_flags(sc_res, sc_c, sc_v);
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    state_d   = ST_DONE;
                    alu_out_d = md_result;
                    flag_d    = pack_flags(md_result, md_carry, md_ovf);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            alu_out_q <= '0;
            flag_q    <= '0;
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            flag_q    <= flag_d;
        end
    end

    alu_muldiv #(
        .WIDTH(WIDTH)
    ) u_md (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start_i  (md_start),
        .op_i     (md_op),
        .a_i      (DATA_A),
        .b_i      (DATA_B),
        .done_o   (md_done),
        .result_o (md_result),
        .carry_o  (md_carry),
        .ovf_o    (md_ovf)
    );

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: expected results queued at issue, checked by a monitor on transfer.
module tb_seq_alu;
    import alu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  s_alu, flag_out;
    logic [15:0] data_a, data_b, alu_out;

    logic        v32_valid, v32_ready, v32_ovalid, v32_oready;
    logic [3:0]  v32_op, v32_flags;
    logic [31:0] v32_a, v32_b, v32_out;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [19:0] exp_q[$];
    string       name_q[$];
    logic [35:0] exp32_q[$];

    always #5 CLK = ~CLK;

    seq_alu #(.WIDTH(16)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(in_valid), .IN_READY(in_ready),
        .S_ALU(s_alu), .DATA_A(data_a), .DATA_B(data_b), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .ALU_OUT(alu_out), .FLAG_OUT(flag_out)
    );

    seq_alu #(.WIDTH(32)) u_dut32 (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(v32_valid), .IN_READY(v32_ready),
        .S_ALU(v32_op), .DATA_A(v32_a), .DATA_B(v32_b), .OUT_VALID(v32_ovalid),
        .OUT_READY(v32_oready), .ALU_OUT(v32_out), .FLAG_OUT(v32_flags)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a result is consumed on the edge after a negedge where valid & ready.
    always @(negedge CLK) begin
        if (RST_N && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL sb_spurious: result 0x%0h flags %b with nothing expected", alu_out, flag_out);
            end else begin
                logic [19:0] e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, "_out"}, alu_out, e[19:4]);
                check({nm, "_flags"}, flag_out, e[3:0]);
            end
        end
        if (RST_N && v32_ovalid && v32_oready) begin
            if (exp32_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL sb32_spurious: result 0x%0h with nothing expected", v32_out);
            end else begin
                logic [35:0] e32;
                e32 = exp32_q.pop_front();
                check("w32_out", v32_out, e32[35:4]);
                check("w32_flags", v32_flags, e32[3:0]);
            end
        end
    end

    // Drivers act 1 time unit after the rising edge; waits returns cycles until accept.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] er, input logic [3:0] ef, input string nm,
                         input bit push, output int waits);
        logic rdy;
        in_valid = 1'b1;
        s_alu    = op;
        data_a   = a;
        data_b   = b;
        if (push) begin
            exp_q.push_back({er, ef});
            name_q.push_back(nm);
        end
        waits = 0;
        rdy   = 1'b0;
        while (!rdy && waits < 200) begin
            @(negedge CLK);
            rdy = in_ready;
            @(posedge CLK);
            #1;
            waits++;
        end
        if (!rdy) check({nm, "_accept_timeout"}, rdy, 1'b1);
        in_valid = 1'b0;
        s_alu    = 4'($urandom_range(0, 15));
        data_a   = 16'($urandom);
        data_b   = 16'($urandom);
    endtask

    task automatic wait_result(input int lat, input string nm);
        int n;
        int busy_rdy;
        n = 1;
        busy_rdy = 0;
        while (!out_valid && n < 200) begin
            if (in_ready) busy_rdy++;
            @(posedge CLK);
            #1;
            n++;
        end
        check({nm, "_latency"}, n, lat);
        check({nm, "_busy_in_ready"}, busy_rdy, 0);
    endtask

    task automatic run(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic [3:0] ef, input int lat, input string nm);
        int w;
        issue(op, a, b, er, ef, nm, 1'b1, w);
        wait_result(lat, nm);
    endtask

    initial begin
        int w;
        int n;
        logic r;
        in_valid = 1'b0; s_alu = 4'h0; data_a = '0; data_b = '0; out_ready = 1'b1;
        v32_valid = 1'b0; v32_op = 4'h0; v32_a = '0; v32_b = '0; v32_oready = 1'b1;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_alu_out", alu_out, 16'h0000);
        check("rst_flags", flag_out, 4'b0000);
        check("rst_in_ready", in_ready, 1'b1);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        run(OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1,  "add_ovf");
        run(OP_SUB,  16'h0000, 16'h0001, 16'hFFFF, 4'b1010, 1,  "sub_borrow");
        run(OP_NON,  16'h1234, 16'h5678, 16'h0000, 4'b1010, 1,  "non_keep");
        run(OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1,  "add_carry_zero");
        run(OP_AND,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1,  "and");
        run(OP_OR,   16'h8000, 16'h0001, 16'h8001, 4'b1000, 1,  "or");
        run(OP_SLL,  16'h8001, 16'h0001, 16'h0002, 4'b0010, 1,  "sll1");
        run(OP_ROL,  16'h8001, 16'h0004, 16'h0018, 4'b0000, 1,  "rol4");
        run(OP_SRA,  16'h8000, 16'h000F, 16'hFFFF, 4'b1000, 1,  "sra15");
        run(OP_SRL,  16'h0003, 16'h0000, 16'h0003, 4'b0000, 1,  "srl0");
        run(OP_SRL,  16'h8001, 16'h0011, 16'h4000, 4'b0010, 1,  "srl_amt_masked");
        run(OP_MUL,  16'h0100, 16'h0100, 16'h0000, 4'b0110, 17, "mul_hi");
        run(OP_MUL,  16'h00FF, 16'h00FF, 16'hFE01, 4'b1000, 17, "mul_ff");
        run(OP_DIVU, 16'd100,  16'd7,    16'd14,   4'b0000, 17, "divu");
        run(OP_REMU, 16'd100,  16'd7,    16'd2,    4'b0000, 17, "remu");
        run(OP_DIVU, 16'h1234, 16'h0000, 16'hFFFF, 4'b1001, 17, "divu_by0");
        run(OP_REMU, 16'h1234, 16'h0000, 16'h1234, 4'b0001, 17, "remu_by0");
        run(4'b1100, 16'h5555, 16'h3333, 16'h0000, 4'b0001, 1,  "undef_op");

        // Backpressure: result must sit still while the consumer stalls.
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        issue(OP_ADD, 16'h1234, 16'h4321, 16'h5555, 4'b0000, "bp_add", 1'b1, w);
        wait_result(1, "bp_add");
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            check("bp_hold_out", alu_out, 16'h5555);
            check("bp_hold_flags", flag_out, 4'b0000);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        issue(OP_XOR, 16'hF0F0, 16'hFFFF, 16'h0F0F, 4'b0000, "b2b_xor", 1'b1, w);
        check("b2b_same_cycle", w, 1);
        wait_result(1, "b2b_xor");

        // Reset in the middle of a multiply: no result may appear.
        @(posedge CLK);
        #1;
        issue(OP_MUL, 16'h0100, 16'h0100, 16'h0000, 4'b0000, "rst_mul", 1'b0, w);
        repeat (8) begin
            @(posedge CLK);
            #1;
        end
        check("rst_mid_count", u_dut.u_md.count_q, 4'd8);
        check("rst_mid_busy", u_dut.state_q, ST_BUSY);
        RST_N = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_alu_out", alu_out, 16'h0000);
        check("rst_mid_flags", flag_out, 4'b0000);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("post_rst_state", u_dut.state_q, ST_IDLE);
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_out_valid", out_valid, 1'b0);
        run(OP_ADD, 16'h0001, 16'h0001, 16'h0002, 4'b0000, 1, "post_rst_add");

        // WIDTH=32 multiply whose product spills entirely into the high half.
        @(posedge CLK);
        #1;
        v32_valid = 1'b1;
        v32_op    = OP_MUL;
        v32_a     = 32'h0001_0000;
        v32_b     = 32'h0001_0000;
        exp32_q.push_back({32'h0000_0000, 4'b0110});
        @(negedge CLK);
        r = v32_ready;
        @(posedge CLK);
        #1;
        check("w32_accept", r, 1'b1);
        v32_valid = 1'b0;
        v32_a     = $urandom;
        v32_b     = $urandom;
        n = 1;
        while (!v32_ovalid && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("w32_mul_latency", n, 33);

        repeat (4) @(posedge CLK);
        #1;
        check("sb_drained", exp_q.size(), 0);
        check("sb32_drained", exp32_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, clocked successor to the combinational datapath ALU. Adds WIDTH generalisation, a valid/ready handshake, registered result and flags, and iterative multi-cycle MUL/DIVU/REMU. Sits between register-file read and writeback. The control unit issues one operation and stalls on IN_READY.

Parameters:
WIDTH, 16, operand/result width in bits (>=4, power of 2)
SHW, $clog2(WIDTH), shift-amount width; local, not overridable

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
IN_VALID  in  1  operation request
IN_READY  out  1  block can accept a request this cycle
S_ALU  in  4  opcode
DATA_A  in  WIDTH  operand A
DATA_B  in  WIDTH  operand B; shifts use DATA_B[SHW-1:0]
OUT_VALID  out  1  ALU_OUT/FLAG_OUT hold a valid result
OUT_READY  in  1  consumer takes the result
ALU_OUT  out  WIDTH  result
FLAG_OUT  out  4  {S,Z,C,V}

Behaviour:
- Clock/reset: one clock (CLK); reset asynchronous, active-low (RST_N). Reset forces state=IDLE, OUT_VALID=0, ALU_OUT=0, FLAG_OUT=0, iteration counter=0. Reset mid-operation aborts it; no result is produced.
- Opcodes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, MUL 0101, DIVU 0110, REMU 0111, SLL 1000, ROL 1001, SRL 1010, SRA 1011, NON 1111. Any other code behaves as NON.
- Handshake: transfer happens when IN_VALID & IN_READY. IN_READY = (state==IDLE) | (state==DONE & OUT_READY), which allows back-to-back issue. Operands and opcode are captured at accept. Later input changes are ignored.
- Output rule: while OUT_VALID & !OUT_READY, ALU_OUT/FLAG_OUT are held stable. OUT_VALID drops the cycle after acceptance unless a new result lands in that same edge.
- States:
  - IDLE: on accept of a single-cycle op -> DONE with the result registered (latency 1). On accept of MUL/DIVU/REMU -> BUSY with count=0.
  - BUSY: one shift-add (MUL) or one restoring-subtract step (DIV) per cycle. At count==WIDTH-1 -> DONE. Total latency is WIDTH+1 cycles from accept to OUT_VALID.
  - DONE: OUT_VALID=1. If OUT_READY & !IN_VALID -> IDLE. If OUT_READY & IN_VALID -> act as IDLE accept.
- Arithmetic is unsigned on WIDTH+1 bits; S = ALU_OUT[WIDTH-1]; Z = (ALU_OUT==0).
  - ADD: C = carry-out. V = signed overflow (A,B same sign, result sign differs).
  - SUB: C = borrow (A<B unsigned). V = A,B signs differ and result sign differs from A.
  - AND/OR/XOR: C=0, V=0.
  - SLL by n: C = A[WIDTH-n] for n>0, else 0.
  - ROL by n: rotate left; C = ALU_OUT[0] for n>0, else 0.
  - SRL/SRA by n: C = A[n-1] for n>0, else 0. SRA replicates the sign bit.
  - V=0 for all shifts and rotates.
  - MUL: ALU_OUT = low WIDTH bits of the unsigned product. C = (high half != 0). V=0.
  - DIVU/REMU: quotient/remainder, unsigned. Divisor 0 -> quotient all-ones, remainder = A, V=1, C=0; still takes WIDTH+1 cycles.
  - NON: accepted, completes in 1 cycle, ALU_OUT=0, FLAG_OUT keeps its previous value.

Decomposition:
- Package alu_pkg: opcode localparams, flag bit indices (FLAG_S=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), state encoding (IDLE/BUSY/DONE).
- Sub-module alu_muldiv(WIDTH): owns the iteration counter, partial product/remainder registers and the done strobe.
- seq_alu keeps the combinational single-cycle path, the FSM and the output registers.

Test Plan:
- WIDTH=16, ADD 0x7FFF+0x0001 -> 1 cycle later OUT_VALID, ALU_OUT=0x8000, FLAG_OUT=1001. SUB 0x0000-0x0001 -> 0xFFFF, FLAG_OUT=1010.
- SLL 0x8001 by 1 -> 0x0002, C=1. ROL 0x8001 by 4 -> 0x0018, C=0. SRA 0x8000 by 15 -> 0xFFFF, C=0. SRL 0x0003 by 0 -> 0x0003, C=0.
- MUL 0x0100*0x0100 -> after 17 cycles ALU_OUT=0x0000, FLAG_OUT=0110 (Z=1, C=1); IN_READY=0 throughout BUSY.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 0x1234/0 -> 0xFFFF, V=1. REMU 0x1234/0 -> 0x1234, V=1.
- Backpressure: hold OUT_READY=0 for 5 cycles after ADD -> outputs stable and IN_READY=0. Then OUT_READY=1 with IN_VALID=1 (XOR 0xF0F0^0xFFFF) -> accepted the same cycle, next ALU_OUT=0x0F0F.
- Deassert RST_N mid-MUL (count=8) -> OUT_VALID=0, ALU_OUT=0 immediately. After release, IDLE with IN_READY=1. Repeat with WIDTH=32: MUL 0x10000*0x10000 -> C=1, Z=1.
